mio_wait_responder: RTL and testbench

- Memory-mapped bus target on the CPU/MIO bus: the responder end of the CPU's request/ready handshake.
- Decodes its address window and completes each access after a programmable number of wait states by asserting MIO_ready.
- Provides a 32-bit FIFO mailbox plus status and control registers, so software can exercise stalled loads and stores against a slow device.
- Sits beside MIO_BUS; its MIO_ready is ANDed into the CPU's ready input at top level.

---
 rtl/mio_wait_responder.sv | 142 ++++++++++++++
 tb/tb_mio_wait_responder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mio_wait_responder.sv
// Wait-state bus target with a 32-bit FIFO mailbox plus status/control registers.
// Optional threshold interrupt is enabled by defining MIO_RESP_IRQ_EN.
module mio_wait_responder #(
  parameter logic [3:0] BASE_NIBBLE = 4'hD,
  parameter int         WAIT_CYCLES = 2,
  parameter int         DEPTH_LOG2  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CPU_MIO,
  input  logic                mem_w,
  input  logic [31:0]         addr_bus,
  input  logic [31:0]         Cpu_data2bus,
  output logic [31:0]         Cpu_data4bus,
  output logic                MIO_ready,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                fifo_empty,
  output logic                fifo_full
`ifdef MIO_RESP_IRQ_EN
  ,
  input  logic [DEPTH_LOG2:0] irq_thresh,
  output logic                fifo_irq
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  lat_w;
  logic [1:0]            lat_sel;
  logic [31:0]           lat_data;
  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic                  overflow, underflow;
  logic [31:0]           mem [DEPTH];
  logic                  hit, irq_bit;
  logic                  do_push, do_pop, do_flush;
  logic [5:0]            count6;
  logic [31:0]           status, rd_data;
  logic                  unused_bits;

  assign hit        = CPU_MIO && (addr_bus[31:28] == BASE_NIBBLE);
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  // Same slot but different lap bit means the writer is a full lap ahead.
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign count6     = 6'(fifo_count);
  assign unused_bits = ^{addr_bus[27:4], addr_bus[1:0]};

`ifdef MIO_RESP_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fifo_irq <= 1'b0;
    else     fifo_irq <= (irq_thresh != '0) && (fifo_count >= irq_thresh);
  end
  assign irq_bit = fifo_irq;
`else
  assign irq_bit = 1'b0;
`endif

  assign status = {21'b0, irq_bit, underflow, overflow, fifo_full, fifo_empty, count6};

  assign do_push  = (state == ACK) && lat_w && (lat_sel == REG_DATA) && !fifo_full;
  assign do_pop   = (state == ACK) && !lat_w && (lat_sel == REG_DATA) && !fifo_empty;
  assign do_flush = (state == ACK) && lat_w && (lat_sel == REG_CTRL) && lat_data[0];

  always_comb begin
    rd_data = 32'h0;
    if (!lat_w) begin
      case (lat_sel)
        REG_DATA:   if (!fifo_empty) rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
        REG_STATUS: rd_data = status;
        default:    rd_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= lat_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      lat_w        <= 1'b0;
      lat_sel      <= '0;
      lat_data     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      MIO_ready    <= 1'b0;
      Cpu_data4bus <= '0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          lat_w    <= mem_w;
          lat_sel  <= addr_bus[3:2];
          lat_data <= Cpu_data2bus;
          wait_cnt <= 4'(WAIT_CYCLES);
          state    <= WAIT;
        end
        WAIT: begin
          if (!CPU_MIO)             state <= IDLE;
          else if (wait_cnt == '0)  state <= ACK;
          else                      wait_cnt <= wait_cnt - 4'd1;
        end
        ACK: begin
          if (do_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
          if (do_push) wr_ptr <= wr_ptr + 1'b1;
          if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
          if (lat_w && lat_sel == REG_DATA && fifo_full)    overflow  <= 1'b1;
          if (!lat_w && lat_sel == REG_DATA && fifo_empty)  underflow <= 1'b1;
          Cpu_data4bus <= rd_data;
          MIO_ready    <= 1'b1;
          state        <= HOLD;
        end
        default: if (!CPU_MIO) begin
          MIO_ready    <= 1'b0;
          Cpu_data4bus <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_wait_responder.sv
// Directed bench for mio_wait_responder: expected read data flows through a scoreboard queue.
module tb_mio_wait_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr_bus = '0;
  logic [31:0] Cpu_data2bus = '0;
  logic [31:0] Cpu_data4bus;
  logic        MIO_ready;
  logic [3:0]  fifo_count;
  logic        fifo_empty, fifo_full;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] sb [$];

  localparam int EXP_LAT = 4;  // WAIT_CYCLES(2) + 2

  mio_wait_responder #(.BASE_NIBBLE(4'hD), .WAIT_CYCLES(2), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w), .addr_bus(addr_bus),
    .Cpu_data2bus(Cpu_data2bus), .Cpu_data4bus(Cpu_data4bus), .MIO_ready(MIO_ready),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; expected read data is queued at issue and popped at MIO_ready.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input int hold);
    int lat;
    int unstable;
    logic [31:0] first, e;
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = w; addr_bus = a; Cpu_data2bus = d;
    if (!w) sb.push_back(exp_rd);
    @(posedge clk);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      addr_bus = 32'h0; Cpu_data2bus = ~d;
      if (MIO_ready) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(EXP_LAT));
    if (!w) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(Cpu_data4bus), 64'(e));
    end
    first = Cpu_data4bus;
    unstable = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!MIO_ready || Cpu_data4bus !== first) unstable++;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(unstable), 64'd0);
    CPU_MIO = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_release"}, {31'b0, MIO_ready, Cpu_data4bus}, 64'd0);
  endtask

  initial begin
    int seen;
    #12;
    @(negedge clk);
    chk("reset_outputs", {MIO_ready, Cpu_data4bus, fifo_count, fifo_empty, fifo_full},
        {1'b0, 32'h0, 4'd0, 1'b1, 1'b0});
    rst = 1'b0;

    // Write then read back; long hold must still pop once.
    xfer("wr_beef", 1'b1, 32'hD000_0000, 32'hDEAD_BEEF, 32'h0, 0);
    chk("wr_beef_count", {fifo_count, fifo_empty}, {4'd1, 1'b0});
    xfer("rd_beef", 1'b0, 32'hD000_0000, 32'h0, 32'hDEAD_BEEF, 10);
    chk("rd_beef_count", {fifo_count, fifo_empty}, {4'd0, 1'b1});

    // Overflow: nine pushes into eight slots.
    for (int i = 1; i <= 9; i++) begin
      xfer("push", 1'b1, 32'hD000_0000, 32'(i), 32'h0, 0);
      if (i == 7) chk("full_before_8", {31'b0, fifo_full}, 64'd0);
      if (i == 8) chk("full_after_8", {fifo_full, fifo_count}, {1'b1, 4'd8});
    end
    chk("count_after_9", {fifo_full, fifo_count}, {1'b1, 4'd8});
    xfer("status_ovf", 1'b0, 32'hD000_0004, 32'h0, 32'h0000_0188, 0);
    for (int i = 1; i <= 8; i++) xfer("pop", 1'b0, 32'hD000_0000, 32'h0, 32'(i), 0);

    // Underflow, reserved and control registers.
    xfer("pop_empty", 1'b0, 32'hD000_0000, 32'h0, 32'h0, 0);
    xfer("status_udf", 1'b0, 32'hD000_0004, 32'h0, 32'h0000_0340, 0);
    xfer("rd_reserved", 1'b0, 32'hD000_000C, 32'h0, 32'h0, 0);
    xfer("wr_reserved", 1'b1, 32'hD000_000C, 32'h1234_5678, 32'h0, 0);
    xfer("rd_ctrl", 1'b0, 32'hD000_0008, 32'h0, 32'h0, 0);
    xfer("wr_ctrl", 1'b1, 32'hD000_0008, 32'h0000_0001, 32'h0, 0);
    xfer("status_clr", 1'b0, 32'hD000_0004, 32'h0, 32'h0000_0040, 0);

    // Address miss.
    xfer("wr_keep", 1'b1, 32'hD000_0000, 32'hA5A5_0001, 32'h0, 0);
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'hE000_0000; Cpu_data2bus = 32'h5555_5555;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (MIO_ready) seen++;
    end
    chk("miss_no_ready", 64'(seen), 64'd0);
    CPU_MIO = 1'b0;
    @(negedge clk);
    chk("miss_fifo", {fifo_count, fifo_empty}, {4'd1, 1'b0});

    // Request dropped during WAIT: no access.
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b0; addr_bus = 32'hD000_0000;
    @(posedge clk);
    @(negedge clk);
    CPU_MIO = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_pop", {MIO_ready, fifo_count}, {1'b0, 4'd1});

    // Reset during WAIT of a pending write.
    @(negedge clk);
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'hD000_0000; Cpu_data2bus = 32'hCAFE_0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid", {MIO_ready, fifo_count, fifo_empty}, {1'b0, 4'd0, 1'b1});
    CPU_MIO = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold", {MIO_ready, fifo_count, fifo_empty}, {1'b0, 4'd0, 1'b1});
    rst = 1'b0;
    xfer("post_rst_wr", 1'b1, 32'hD000_0000, 32'h0BAD_F00D, 32'h0, 0);
    xfer("post_rst_rd", 1'b0, 32'hD000_0000, 32'h0, 32'h0BAD_F00D, 3);
    chk("final_empty", {fifo_count, fifo_empty}, {4'd0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
